// File: rtl/fwd_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fwd_hazard_ctrl_pkg
// Brief    : Shared types and constants for the forwarding/hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package fwd_hazard_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    typedef struct packed {
        logic [REG_AW_DEF-1:0] rs;
        logic [REG_AW_DEF-1:0] rt;
        logic [REG_AW_DEF-1:0] dst;
        logic                  regwrite;
        logic                  memread;
        logic                  use_rt;
    } stage_info_t;

    localparam stage_info_t BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : fwd_hazard_ctrl_if
// Brief     : ID-stage hazard inputs and forwarding/stall outputs.
// Revision  : 1.0 - initial release
// ============================================================================
interface fwd_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic              id_use_rt_i;
    logic [REG_AW-1:0] id_dst_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              flush_i;
    logic [1:0]        fwd_a_sel_o;
    logic [1:0]        fwd_b_sel_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rt_i, id_dst_i,
               id_regwrite_i, id_memread_i, flush_i,
        input  fwd_a_sel_o, fwd_b_sel_o, stall_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rt_i, id_dst_i,
               id_regwrite_i, id_memread_i, flush_i,
        output fwd_a_sel_o, fwd_b_sel_o, stall_o, stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel_logic
// Brief    : Picks the forwarding source for one ALU operand (MEM over WB).
// Revision : 1.0 - initial release
// ============================================================================
module fwd_sel_logic
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  wire logic [REG_AW-1:0] i_src,
    input  wire logic              i_src_used,
    input  wire logic              i_mem_regwrite,
    input  wire logic [REG_AW-1:0] i_mem_dst,
    input  wire logic              i_wb_regwrite,
    input  wire logic [REG_AW-1:0] i_wb_dst,
    output fwd_sel_t               o_sel
);
    logic w_src_live;
    logic w_hit_mem;
    logic w_hit_wb;

    // $0 is hard-wired, so it never matches a producer
    assign w_src_live = i_src_used && (i_src != '0);
    assign w_hit_mem  = w_src_live && i_mem_regwrite && (i_mem_dst == i_src);
    assign w_hit_wb   = w_src_live && i_wb_regwrite  && (i_wb_dst  == i_src);

    always_comb begin
        o_sel = FWD_REG;
        if (w_hit_mem) begin
            o_sel = FWD_MEM;
        end else if (w_hit_wb) begin
            o_sel = FWD_WB;
        end
    end
endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_ctrl
// Brief    : Operand forwarding and load-use stall control for a 5-stage pipe.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    fwd_hazard_ctrl_if.slave bus
);
    stage_info_t      r_ex;
    stage_info_t      r_mem;
    stage_info_t      r_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    stage_info_t      w_id;
    logic             w_ex_load;
    logic             w_stall;
    logic             w_ex_advance;
    fwd_sel_t         w_sel_a;
    fwd_sel_t         w_sel_b;
    logic             w_unused_fields;

    always_comb begin
        w_id          = BUBBLE;
        w_id.rs       = bus.id_rs_i;
        w_id.rt       = bus.id_rt_i;
        w_id.dst      = bus.id_dst_i;
        w_id.regwrite = bus.id_regwrite_i;
        w_id.memread  = bus.id_memread_i;
        w_id.use_rt   = bus.id_use_rt_i;
    end

    // A load in EX only has its data after MEM, too late for the next EX
    assign w_ex_load = r_ex.memread && r_ex.regwrite && (r_ex.dst != '0);
    assign w_stall   = !bus.flush_i && bus.id_valid_i && w_ex_load &&
                       ((r_ex.dst == bus.id_rs_i) ||
                        (bus.id_use_rt_i && (r_ex.dst == bus.id_rt_i)));

    assign w_ex_advance = bus.id_valid_i && !w_stall && !bus.flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex        <= BUBBLE;
            r_mem       <= BUBBLE;
            r_wb        <= BUBBLE;
            r_stall_cnt <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_ex_advance ? w_id : BUBBLE;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    fwd_sel_logic #(.REG_AW(REG_AW)) u_sel_a (
        .i_src          (r_ex.rs),
        .i_src_used     (1'b1),
        .i_mem_regwrite (r_mem.regwrite),
        .i_mem_dst      (r_mem.dst),
        .i_wb_regwrite  (r_wb.regwrite),
        .i_wb_dst       (r_wb.dst),
        .o_sel          (w_sel_a)
    );

    fwd_sel_logic #(.REG_AW(REG_AW)) u_sel_b (
        .i_src          (r_ex.rt),
        .i_src_used     (r_ex.use_rt),
        .i_mem_regwrite (r_mem.regwrite),
        .i_mem_dst      (r_mem.dst),
        .i_wb_regwrite  (r_wb.regwrite),
        .i_wb_dst       (r_wb.dst),
        .o_sel          (w_sel_b)
    );

    assign bus.fwd_a_sel_o = w_sel_a;
    assign bus.fwd_b_sel_o = w_sel_b;
    assign bus.stall_o     = w_stall;
    assign bus.stall_cnt_o = r_stall_cnt;

    assign w_unused_fields = ^{r_mem.rs, r_mem.rt, r_mem.memread, r_mem.use_rt,
                               r_wb.rs, r_wb.rt, r_wb.memread, r_wb.use_rt};
endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_ctrl
// Brief    : Directed bench with an instruction-level pipeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();
    fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  bus_s ();

    assign bus_s.id_valid_i    = bus.id_valid_i;
    assign bus_s.id_rs_i       = bus.id_rs_i;
    assign bus_s.id_rt_i       = bus.id_rt_i;
    assign bus_s.id_use_rt_i   = bus.id_use_rt_i;
    assign bus_s.id_dst_i      = bus.id_dst_i;
    assign bus_s.id_regwrite_i = bus.id_regwrite_i;
    assign bus_s.id_memread_i  = bus.id_memread_i;
    assign bus_s.flush_i       = bus.flush_i;

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_s)
    );

    // ---------------- instruction-level model ----------------
    typedef struct {
        bit v;
        int rs;
        int rt;
        int dst;
        bit urt;
        bit wr;
        bit ld;
    } ins_t;

    ins_t pipe [3];          // 0 = EX, 1 = MEM, 2 = WB
    int   total_stalls = 0;
    bit   model_ok = 1'b0;

    function automatic bit exp_stall();
        ins_t e = pipe[0];
        if (bus.flush_i || !bus.id_valid_i) return 1'b0;
        if (!(e.v && e.ld && e.wr) || e.dst == 0) return 1'b0;
        return (e.dst == int'(bus.id_rs_i)) ||
               (bus.id_use_rt_i && e.dst == int'(bus.id_rt_i));
    endfunction

    // Newest older producer of src wins; its stage names the mux input
    function automatic logic [1:0] exp_fwd(int src, bit used);
        if (!used || src == 0) return 2'b00;
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].v && pipe[k].wr && pipe[k].dst == src)
                return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic int sat(int n, int max);
        return (n > max) ? max : n;
    endfunction

    always @(posedge clk) begin : model_step
        bit s;
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
            total_stalls = 0;
            model_ok = 1'b1;
        end else begin
            s = exp_stall();
            if (s) total_stalls++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (bus.id_valid_i && !s && !bus.flush_i)
                pipe[0] = '{1'b1, int'(bus.id_rs_i), int'(bus.id_rt_i),
                            int'(bus.id_dst_i), bus.id_use_rt_i,
                            bus.id_regwrite_i, bus.id_memread_i};
            else
                pipe[0] = '{default: 0};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            check("fwd_a", 32'(bus.fwd_a_sel_o), 32'(exp_fwd(pipe[0].rs, 1'b1)));
            check("fwd_b", 32'(bus.fwd_b_sel_o), 32'(exp_fwd(pipe[0].rt, pipe[0].urt)));
            check("stall", 32'(bus.stall_o), 32'(exp_stall()));
            check("stall_cnt", 32'(bus.stall_cnt_o), 32'(sat(total_stalls, 65535)));
            check("sat_stall", 32'(bus_s.stall_o), 32'(exp_stall()));
            check("sat_stall_cnt", 32'(bus_s.stall_cnt_o), 32'(sat(total_stalls, 3)));
            if (pipe[1].ld)
                check("no_mem_fwd_of_load",
                      32'((bus.fwd_a_sel_o == 2'b10) || (bus.fwd_b_sel_o == 2'b10)), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int rs, input int rt, input bit urt,
                         input int dst, input bit wr, input bit ld, input bit fl);
        @(posedge clk);
        #1;
        bus.id_valid_i    = v;
        bus.id_rs_i       = rs[4:0];
        bus.id_rt_i       = rt[4:0];
        bus.id_use_rt_i   = urt;
        bus.id_dst_i      = dst[4:0];
        bus.id_regwrite_i = wr;
        bus.id_memread_i  = ld;
        bus.flush_i       = fl;
        @(negedge clk);
    endtask

    task automatic nop();
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // ID contents are held upstream while the model says the pipe stalls
    task automatic issue(input int rs, input int rt, input bit urt,
                         input int dst, input bit wr, input bit ld);
        int guard = 0;
        drive(1'b1, rs, rt, urt, dst, wr, ld, 1'b0);
        while (exp_stall() && guard < 4) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        if (guard >= 4) begin
            errors++;
            $display("FAIL issue_timeout: stall held %0d cycles, expected at most 1", guard);
        end
    endtask

    initial begin
        bus.id_valid_i = 1'b0; bus.id_rs_i = '0; bus.id_rt_i = '0;
        bus.id_use_rt_i = 1'b0; bus.id_dst_i = '0; bus.id_regwrite_i = 1'b0;
        bus.id_memread_i = 1'b0; bus.flush_i = 1'b0;

        // reset then idle
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("pin_rst_fwd_a", 32'(bus.fwd_a_sel_o), 32'd0);
        check("pin_rst_fwd_b", 32'(bus.fwd_b_sel_o), 32'd0);
        check("pin_rst_stall", 32'(bus.stall_o), 32'd0);
        check("pin_rst_cnt", 32'(bus.stall_cnt_o), 32'd0);
        nop();

        // add $3,$1,$2 ; sub $4,$3,$5
        issue(1, 2, 1'b1, 3, 1'b1, 1'b0);
        issue(3, 5, 1'b1, 4, 1'b1, 1'b0);
        nop();
        check("pin_exmem_a", 32'(bus.fwd_a_sel_o), 32'h2);
        check("pin_exmem_b", 32'(bus.fwd_b_sel_o), 32'h0);
        nop(); nop();

        // add $3 ; add $3 ; or $6,$3,$3 -> MEM wins
        issue(1, 2, 1'b1, 3, 1'b1, 1'b0);
        issue(4, 5, 1'b1, 3, 1'b1, 1'b0);
        issue(3, 3, 1'b1, 6, 1'b1, 1'b0);
        nop();
        check("pin_prio_a", 32'(bus.fwd_a_sel_o), 32'h2);
        check("pin_prio_b", 32'(bus.fwd_b_sel_o), 32'h2);
        nop(); nop();

        // add $3 ; add $9 ; or $6,$3,$3 -> WB forwarding
        issue(1, 2, 1'b1, 3, 1'b1, 1'b0);
        issue(4, 5, 1'b1, 9, 1'b1, 1'b0);
        issue(3, 3, 1'b1, 6, 1'b1, 1'b0);
        nop();
        check("pin_wb_a", 32'(bus.fwd_a_sel_o), 32'h1);
        check("pin_wb_b", 32'(bus.fwd_b_sel_o), 32'h1);
        nop(); nop();

        // lw $7,0($1) ; add $8,$7,$2
        issue(1, 7, 1'b0, 7, 1'b1, 1'b1);
        drive(1'b1, 7, 2, 1'b1, 8, 1'b1, 1'b0, 1'b0);
        check("pin_lu_stall", 32'(bus.stall_o), 32'd1);
        check("pin_lu_cnt0", 32'(bus.stall_cnt_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("pin_lu_stall_gone", 32'(bus.stall_o), 32'd0);
        check("pin_lu_cnt1", 32'(bus.stall_cnt_o), 32'd1);
        nop();
        check("pin_lu_fwd_a", 32'(bus.fwd_a_sel_o), 32'h1);
        nop(); nop();

        // load-use coinciding with flush
        issue(1, 7, 1'b0, 7, 1'b1, 1'b1);
        drive(1'b1, 7, 2, 1'b1, 8, 1'b1, 1'b0, 1'b1);
        check("pin_flush_stall", 32'(bus.stall_o), 32'd0);
        check("pin_flush_cnt", 32'(bus.stall_cnt_o), 32'd1);
        nop();
        check("pin_flush_fwd_a", 32'(bus.fwd_a_sel_o), 32'h0);
        check("pin_flush_fwd_b", 32'(bus.fwd_b_sel_o), 32'h0);
        nop(); nop();

        // zero register: add $0 ; add $5,$0,$0 ; lw $0 then use $0
        issue(1, 2, 1'b1, 0, 1'b1, 1'b0);
        issue(0, 0, 1'b1, 5, 1'b1, 1'b0);
        nop();
        check("pin_zero_a", 32'(bus.fwd_a_sel_o), 32'h0);
        check("pin_zero_b", 32'(bus.fwd_b_sel_o), 32'h0);
        issue(1, 0, 1'b0, 0, 1'b1, 1'b1);
        drive(1'b1, 0, 0, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        check("pin_zero_nostall", 32'(bus.stall_o), 32'd0);
        nop(); nop(); nop();

        // five more load-use stalls: 2-bit counter saturates
        for (int i = 0; i < 5; i++) begin
            issue(1, 7, 1'b0, 7, 1'b1, 1'b1);
            issue(7, 2, 1'b1, 8, 1'b1, 1'b0);
        end
        nop(); nop(); nop();
        check("pin_sat_cnt", 32'(bus_s.stall_cnt_o), 32'd3);
        check("pin_wide_cnt", 32'(bus.stall_cnt_o), 32'd6);

        // reset on the same edge as a stall
        issue(1, 7, 1'b0, 7, 1'b1, 1'b1);
        drive(1'b1, 7, 2, 1'b1, 8, 1'b1, 1'b0, 1'b0);
        check("pin_rststall_stall", 32'(bus.stall_o), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.id_valid_i = 1'b0;
        @(negedge clk);
        check("pin_rststall_cnt", 32'(bus.stall_cnt_o), 32'd0);
        check("pin_rststall_sat", 32'(bus_s.stall_cnt_o), 32'd0);
        nop(); nop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
